// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer behind the UART receiver: first-word-fall-through
// FIFO of {ferr, data} entries with a sticky overrun flag and occupancy status.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_ferr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_ferr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_ferr_q, out_ferr_d;
    logic                  pop, push, drop, mem_we;

    always_comb begin
        pop        = !empty_q && out_ready;
        push       = in_valid && (!full_q || pop);
        drop       = in_valid && full_q && !pop;
        mem_we     = push && !clear;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        out_data_d = out_data_q;
        out_ferr_d = out_ferr_q;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            overrun_d = drop || (overrun_q && !overrun_clr);
            // Head slot being written this cycle is not in memory yet: bypass.
            if (count_d != '0) begin
                if (push && wr_ptr_q == rd_ptr_d) begin
                    out_data_d = in_data;
                    out_ferr_d = in_ferr;
                end else begin
                    out_data_d = mem_q[rd_ptr_d][DATA_WIDTH-1:0];
                    out_ferr_d = mem_q[rd_ptr_d][DATA_WIDTH];
                end
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        afull_d = (count_d >= CW'(AFULL_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= {in_ferr, in_data};
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overrun_q  <= 1'b0;
            out_data_q <= '0;
            out_ferr_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overrun_q  <= overrun_d;
            out_data_q <= out_data_d;
            out_ferr_q <= out_ferr_d;
        end
    end

    assign out_valid   = !empty_q;
    assign out_data    = out_data_q;
    assign out_ferr    = out_ferr_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ferr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ferr;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overrun;
    logic       overrun_clr;

    int total = 0;
    int bad   = 0;

    logic [8:0] mq[$];
    logic       movr;
    logic [7:0] got[$];

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       fe;
        logic       rdy;
        logic       clr;
        int         ecount;
        logic       evalid;
        logic [7:0] edata;
        logic       eovr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clk(clk), .areset_n(areset_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ferr(in_ferr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ferr(out_ferr),
        .count(count), .empty(empty), .full(full),
        .almost_full(almost_full), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        int n;
        n = mq.size();
        check("count", int'(count), n);
        check("empty", int'(empty), int'(n == 0));
        check("full", int'(full), int'(n == 16));
        check("almost_full", int'(almost_full), int'(n >= 12));
        check("out_valid", int'(out_valid), int'(n != 0));
        check("overrun", int'(overrun), int'(movr));
        if (n != 0) begin
            check("out_data", int'(out_data), int'(mq[0][7:0]));
            check("out_ferr", int'(out_ferr), int'(mq[0][8]));
        end
    endfunction

    // Called at posedge+1; applies one cycle of inputs and checks afterwards.
    task automatic step(input logic iv, input logic [7:0] d, input logic fe,
                        input logic rdy, input logic clr, input logic oclr);
        logic pop, isfull, drop;
        in_valid = iv; in_data = d; in_ferr = fe;
        out_ready = rdy; clear = clr; overrun_clr = oclr;
        #1;
        if (out_valid && rdy && !clr) got.push_back(out_data);
        if (clr) begin
            mq.delete();
            movr = 1'b0;
        end else begin
            pop    = (mq.size() != 0) && rdy;
            isfull = (mq.size() == 16);
            drop   = iv && isfull && !pop;
            if (pop) void'(mq.pop_front());
            if (iv && (!isfull || pop)) mq.push_back({fe, d});
            movr = drop ? 1'b1 : (oclr ? 1'b0 : movr);
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() != 0 && guard < 40) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check("drain_bound", int'(mq.size()), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
        vecs[4] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h66, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

        areset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_ferr = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0; movr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        areset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].fe, vecs[i].rdy, vecs[i].clr, 1'b0);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].ecount);
            check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].evalid));
            check($sformatf("vec%0d_ovr", i), int'(overrun), int'(vecs[i].eovr));
            if (vecs[i].evalid)
                check($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].edata));
        end

        // Fill to full, watching almost_full cross at 12.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            check("afull_edge", int'(almost_full), int'(i >= 11));
        end
        check("full_at16", int'(full), 1);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pushpop_cnt", int'(count), 16);
        check("pushpop_ovr", int'(overrun), 0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_ovr", int'(overrun), 1);
        check("drop_cnt", int'(count), 16);
        step(1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1);
        check("set_wins", int'(overrun), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr", int'(overrun), 0);
        got.delete();
        drain();
        check("drain_len", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check("drain_order", int'(got[i]), (i == 15) ? 'h77 : i + 1);

        // Wrap-around with a fixed ready pattern.
        got.delete();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, (i % 3) != 0, 1'b0, 1'b0);
            check("wrap_max", int'(count <= 16), 1);
        end
        drain();
        check("wrap_len", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++)
            check("wrap_order", int'(got[i]), 'h80 + i);

        // Framing-error flag follows its byte.
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("ferr_tag", int'(out_ferr), int'(out_data == 8'h3C));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) == 0);

        // Asynchronous reset mid-cycle with five entries and overrun set.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_cnt", int'(count), 5);
        #1;
        areset_n = 1'b0;
        #1;
        mq.delete();
        movr = 1'b0;
        check_model();
        check("arst_data", int'(out_data), 0);
        check("arst_ferr", int'(out_ferr), 0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_empty", int'(empty), 1);
        check("clr_ovr", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side elastic buffer placed directly downstream of the UART receiver. It captures each byte the receiver produces, together with that byte's framing-error flag, and hands the bytes to the host side through a valid/ready interface. The receiver cannot be stalled, so a byte that arrives while the buffer is full is dropped and recorded in a sticky overrun flag. It also provides occupancy status for flow-control decisions.

## Interface
Parameters:
- DATA_WIDTH, 8: byte width from receiver.
- DEPTH, 16: entries; power of two, ≥2.
- AFULL_LEVEL, 12: almost_full threshold; 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- in_valid  in  1  receiver byte strobe; one-cycle pulse per byte, no backpressure.
- in_data  in  DATA_WIDTH  received byte.
- in_ferr  in  1  framing error for in_data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  DATA_WIDTH  head byte.
- out_ferr  out  1  head byte's framing error.
- count  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count ≥ AFULL_LEVEL.
- overrun  out  1  sticky: a byte was dropped.
- overrun_clr  in  1  clears overrun.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) array holding {ferr, data}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy comes from a registered count.
- Push: in_valid && (!full || pop). Pop: out_valid && out_ready.
- Drop: in_valid && full && !pop. The byte is discarded, overrun is set, and state is otherwise unchanged.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Output is first-word-fall-through. out_valid = !empty. out_data and out_ferr always present the head entry. When out_valid=0 they hold their last value, which is don't-care.
- clear: pointers and count go to 0 and overrun goes to 0. clear has priority over a same-cycle in_valid (byte discarded, no overrun) and over a same-cycle pop.
- overrun: set on a drop, cleared by overrun_clr. If set and clear occur in the same cycle, set wins.
- Status flags (empty, full, almost_full) are registered, derived from the next-state count.
- Reset (areset_n=0, asynchronous): count=0, empty=1, full=0, almost_full=0, out_valid=0, overrun=0, out_data=0, out_ferr=0, pointers=0. Memory contents are not reset. Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Write-to-read latency: a byte pushed into an empty FIFO at edge N gives out_valid=1, with data, after edge N (visible in cycle N+1).
- A pop at edge N presents the next entry in cycle N+1. Back-to-back pops sustain 1 byte/cycle.
- Full with simultaneous push and pop: both occur and count stays at DEPTH.
- Empty with in_valid and out_ready both high: push only, because out_valid=0.
- count, empty, full, almost_full and overrun all update on the same edge as the causing event.
- Release of areset_n is synchronous to clk externally. The first push can be accepted on the first edge after release.

## Test plan
- Reset, then push 0xA5 with ferr=0 → next cycle out_valid=1, out_data=0xA5, out_ferr=0, count=1, empty=0. Pop → empty=1, count=0.
- out_ready=0, push 0x00..0x0F → almost_full rises with count=12; full=1 at count=16. Push 0x55 → dropped, overrun=1, count=16. Drain → 0x00..0x0F in order, with 0x55 absent.
- Full FIFO, push 0x77 in the same cycle as a pop → no overrun, count stays 16, 0x77 is the last byte out. Then assert overrun_clr together with a drop → overrun stays 1.
- Wrap-around: 40 pushes of 0x80+i with out_ready toggling on a fixed pattern → all 40 bytes are read back in order, count never exceeds 16, and the final count matches pushes minus pops.
- Push 0x3C with ferr=1, surrounded by ferr=0 bytes → out_ferr=1 only while out_data=0x3C.
- count=5, assert areset_n low mid-cycle → all outputs return to reset values immediately, before any edge. After release, clear asserted together with in_valid → empty stays 1 and overrun=0.
